// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I datapath: opcodes, ALU_Op codes,
// ALU source-select encodings and main-FSM state encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] ALUOP_R   = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_LUI = 3'b111;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REG  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_EXEC_U   = 4'd8;
  localparam logic [3:0] S_ALU_WB   = 4'd9;
  localparam logic [3:0] S_HALT     = 4'd15;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LUI) ||
           (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: increments on enable, wraps modulo 2^RETIRE_W,
// asynchronous active-low clear.
module retire_counter #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  output logic [RETIRE_W-1:0] count_o
);

  logic [RETIRE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I datapath (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Build option: ILLEGAL_TRAP_EN -> unsupported opcodes halt the FSM until reset.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          Opcode_i,
  input  logic                Mem_Ready_i,
  output logic                Mem_Req_o,
  output logic                Mem_Write_o,
  output logic                IorD_o,
  output logic                IR_Write_o,
  output logic                PC_Write_o,
  output logic                Reg_Write_o,
  output logic                Mem_to_Reg_o,
  output logic [1:0]          ALU_Src_A_o,
  output logic [1:0]          ALU_Src_B_o,
  output logic [2:0]          ALU_Op_o,
  output logic [RETIRE_W-1:0] Retired_Count_o,
  output logic                Illegal_o,
  output logic [STATE_W-1:0]  State_o
);

  logic [3:0] state_q, state_d;
  logic       decode_illegal;
  logic       retire_en;
  logic       mem_req, ir_write, pc_write;

  assign decode_illegal = (state_q == S_DECODE) && !op_supported(Opcode_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (Mem_Ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode_i)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LUI:            state_d = S_EXEC_U;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_HALT;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        if (Opcode_i == OP_LOAD)       state_d = S_MEM_RD;
        else if (Opcode_i == OP_STORE) state_d = S_MEM_WR;
        else                           state_d = S_FETCH;
      end
      S_MEM_RD:   if (Mem_Ready_i) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (Mem_Ready_i) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    mem_req      = 1'b0;
    Mem_Write_o  = 1'b0;
    IorD_o       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    Reg_Write_o  = 1'b0;
    Mem_to_Reg_o = 1'b0;
    ALU_Src_A_o  = SRCA_PC;
    ALU_Src_B_o  = SRCB_REG;
    ALU_Op_o     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        ALU_Src_B_o = SRCB_FOUR;
        ir_write    = Mem_Ready_i;
        pc_write    = Mem_Ready_i;
      end
      S_DECODE:   ALU_Src_B_o = SRCB_IMM;
      S_MEM_ADDR: begin
        ALU_Src_A_o = SRCA_REG;
        ALU_Src_B_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD_o  = 1'b1;
      end
      S_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_req     = 1'b1;
        IorD_o      = 1'b1;
        Mem_Write_o = 1'b1;
      end
      S_EXEC_R: begin
        ALU_Src_A_o = SRCA_REG;
        ALU_Op_o    = ALUOP_R;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = SRCA_REG;
        ALU_Src_B_o = SRCB_IMM;
      end
      S_EXEC_U: begin
        ALU_Src_A_o = SRCA_ZERO;
        ALU_Src_B_o = SRCB_IMM;
        ALU_Op_o    = ALUOP_LUI;
      end
      S_ALU_WB:   Reg_Write_o = 1'b1;
      default: ;
    endcase
  end

  // Reset forces state to FETCH, whose request and Mealy write enables must not leak out while held.
  assign Mem_Req_o  = mem_req  & reset;
  assign IR_Write_o = ir_write & reset;
  assign PC_Write_o = pc_write & reset;

`ifdef ILLEGAL_TRAP_EN
  assign Illegal_o = decode_illegal || (state_q == S_HALT);
  assign retire_en = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                     ((state_q == S_MEM_WR) && Mem_Ready_i);
`else
  assign Illegal_o = decode_illegal;
  assign retire_en = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                     ((state_q == S_MEM_WR) && Mem_Ready_i) || decode_illegal;
`endif

  assign State_o = STATE_W'(state_q);

  retire_counter #(
    .RETIRE_W (RETIRE_W)
  ) u_retire_counter (
    .clk     (clk),
    .clr_n   (reset),
    .en      (retire_en),
    .count_o (Retired_Count_o)
  );

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: instruction-level trace model,
// directed and random instruction streams, reset-abort and counter-wrap cases.
module tb_multicycle_main_control;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BAD = 7'b1111111;
  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4, MS = 4'd5,
                         ER = 4'd6, EI = 4'd7, EU = 4'd8, AW = 4'd9, HT = 4'd15;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] opcode;
  logic ready;

  logic        req, wr, iord, irw, pcw, regw, m2r, ill;
  logic [1:0]  sa, sb;
  logic [2:0]  aop;
  logic [31:0] cnt;
  logic [3:0]  st;

  logic        s_req, s_wr, s_iord, s_irw, s_pcw, s_regw, s_m2r, s_ill;
  logic [1:0]  s_sa, s_sb;
  logic [2:0]  s_aop;
  logic [2:0]  s_cnt;
  logic [3:0]  s_st;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  typedef struct {
    logic [6:0] op;
    logic       rdy;
    logic [3:0] st;
    logic       req, wr, iord, irw, pcw, regw, m2r, ill, ret;
    logic [1:0] sa, sb;
    logic [2:0] aop;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
  } instr_t;

  vec_t q[$];

  always #5 clk = ~clk;

  multicycle_main_control #(.RETIRE_W(32), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode_i(opcode), .Mem_Ready_i(ready),
    .Mem_Req_o(req), .Mem_Write_o(wr), .IorD_o(iord), .IR_Write_o(irw),
    .PC_Write_o(pcw), .Reg_Write_o(regw), .Mem_to_Reg_o(m2r),
    .ALU_Src_A_o(sa), .ALU_Src_B_o(sb), .ALU_Op_o(aop),
    .Retired_Count_o(cnt), .Illegal_o(ill), .State_o(st)
  );

  // Narrow-counter instance on the same stimulus exercises wrap-around.
  multicycle_main_control #(.RETIRE_W(3), .STATE_W(4)) dut_small (
    .clk(clk), .reset(reset), .Opcode_i(opcode), .Mem_Ready_i(ready),
    .Mem_Req_o(s_req), .Mem_Write_o(s_wr), .IorD_o(s_iord), .IR_Write_o(s_irw),
    .PC_Write_o(s_pcw), .Reg_Write_o(s_regw), .Mem_to_Reg_o(s_m2r),
    .ALU_Src_A_o(s_sa), .ALU_Src_B_o(s_sb), .ALU_Op_o(s_aop),
    .Retired_Count_o(s_cnt), .Illegal_o(s_ill), .State_o(s_st)
  );

  function automatic logic legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LUI || op == OP_LD || op == OP_ST;
  endfunction

  // Expected output record for one cycle spent in a named phase.
  function automatic vec_t cyc(input logic [3:0] s, input logic [6:0] op, input logic rdy);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = s;
    v.req = 0; v.wr = 0; v.iord = 0; v.irw = 0; v.pcw = 0; v.regw = 0; v.m2r = 0;
    v.ill = 0; v.ret = 0; v.sa = 2'b00; v.sb = 2'b00; v.aop = 3'b001;
    case (s)
      FE: begin v.req = 1; v.sb = 2'b01; v.irw = rdy; v.pcw = rdy; end
      DE: begin
        v.sb = 2'b10; v.ill = !legal(op);
`ifndef ILLEGAL_TRAP_EN
        v.ret = !legal(op);
`endif
      end
      MA: begin v.sa = 2'b01; v.sb = 2'b10; end
      MR: begin v.req = 1; v.iord = 1; end
      MW: begin v.regw = 1; v.m2r = 1; v.ret = 1; end
      MS: begin v.req = 1; v.iord = 1; v.wr = 1; v.ret = rdy; end
      ER: begin v.sa = 2'b01; v.aop = 3'b000; end
      EI: begin v.sa = 2'b01; v.sb = 2'b10; end
      EU: begin v.sa = 2'b10; v.sb = 2'b10; v.aop = 3'b111; end
      AW: begin v.regw = 1; v.ret = 1; end
      HT: v.ill = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  // Expand one instruction into its expected cycle trace; opcode is garbage outside the sampled phases.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) q.push_back(cyc(FE, junk(), 1'b0));
    q.push_back(cyc(FE, junk(), 1'b1));
    q.push_back(cyc(DE, op, 1'($urandom)));
    if (op == OP_R || op == OP_I || op == OP_LUI) begin
      q.push_back(cyc(op == OP_R ? ER : op == OP_I ? EI : EU, junk(), 1'($urandom)));
      q.push_back(cyc(AW, junk(), 1'($urandom)));
    end else if (op == OP_LD || op == OP_ST) begin
      q.push_back(cyc(MA, op, 1'($urandom)));
      for (int i = 0; i < mw; i++) q.push_back(cyc(op == OP_LD ? MR : MS, junk(), 1'b0));
      q.push_back(cyc(op == OP_LD ? MR : MS, junk(), 1'b1));
      if (op == OP_LD) q.push_back(cyc(MW, junk(), 1'($urandom)));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {13'd0, v.st, v.req, v.wr, v.iord, v.irw, v.pcw, v.regw, v.m2r,
            v.sa, v.sb, v.aop, v.ill};
  endfunction

  // Drive each queued cycle after the edge, check mid-cycle, then advance.
  task automatic run_queue();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      opcode = v.op;
      ready  = v.rdy;
      #4;
      check("outputs", {13'd0, st, req, wr, iord, irw, pcw, regw, m2r, sa, sb, aop, ill},
            pack_exp(v));
      check("small_outputs", {13'd0, s_st, s_req, s_wr, s_iord, s_irw, s_pcw, s_regw, s_m2r,
                              s_sa, s_sb, s_aop, s_ill}, pack_exp(v));
      check("retired_count", cnt, exp_cnt);
      check("retired_count_w3", {29'd0, s_cnt}, {29'd0, exp_cnt[2:0]});
      if (v.ret) exp_cnt = exp_cnt + 1;
      @(posedge clk);
      #1;
    end
  endtask

  instr_t dir [5];
  logic [6:0] ops [5];

  initial begin
    dir[0] = '{OP_I,   0, 0};
    dir[1] = '{OP_LD,  3, 2};
    dir[2] = '{OP_ST,  1, 2};
    dir[3] = '{OP_R,   0, 0};
    dir[4] = '{OP_LUI, 2, 0};
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LUI; ops[3] = OP_LD; ops[4] = OP_ST;

    reset = 1'b0; opcode = '0; ready = 1'b0; exp_cnt = '0;
    #3;
    check("reset_state", {28'd0, st}, 32'd0);
    check("reset_mem_req", {31'd0, req}, 32'd0);
    check("reset_count", cnt, 32'd0);
    check("reset_illegal", {31'd0, ill}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (dir[i]) add_instr(dir[i].op, dir[i].fw, dir[i].mw);
    run_queue();

    for (int n = 0; n < 40; n++)
      add_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3));
    run_queue();

    // Abort a store while it waits for memory.
    add_instr(OP_ST, 0, 0);
    void'(q.pop_back());
    q.push_back(cyc(MS, junk(), 1'b0));
    run_queue();
    ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = '0;
    check("abort_mem_req", {31'd0, req}, 32'd0);
    check("abort_state", {28'd0, st}, 32'd0);
    check("abort_count", cnt, 32'd0);
    check("abort_count_w3", {29'd0, s_cnt}, 32'd0);
    check("abort_enables", {28'd0, wr, regw, irw, pcw}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    add_instr(OP_I, 0, 0);
    add_instr(OP_BAD, 1, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++) q.push_back(cyc(HT, junk(), 1'($urandom)));
`else
    add_instr(OP_ST, 0, 1);
`endif
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
